ovl_window_mc: RTL
==================

OVL_WINDOW_MC -- requirements
Module: ovl_window_mc

Interface
REQ-001 Parameter NUM_CH, default 4: number of independent window channels (1..16).
REQ-002 Parameter WIDTH, default 1: test_expr bits per channel; the condition is true only when all WIDTH bits are 1.
REQ-003 Parameter MAX_WIN, default 16: maximum open-window length in cycles; 0 disables the timeout check.
REQ-004 Parameter CNT_W, default 8: width of the saturating fire counter.
REQ-005 clock  input  1  single clock; all state updates on the posedge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 enable  input  1  global check enable; 0 forces every channel to IDLE and suppresses fire.
REQ-008 start_event  input  NUM_CH  per-channel window open request.
REQ-009 end_event  input  NUM_CH  per-channel window close request.
REQ-010 test_expr  input  NUM_CH*WIDTH  per-channel condition; channel c occupies bits [c*WIDTH +: WIDTH].
REQ-011 active  output  NUM_CH  1 while the channel window is open (registered state).
REQ-012 fire  output  NUM_CH  registered one-cycle pulse per detected violation.
REQ-013 fire_code  output  NUM_CH*2  per-channel cause, valid with fire: 01 = test_expr false in window, 10 = window timeout, 00 otherwise.
REQ-014 fire_count  output  CNT_W  total violations since reset, saturating at all-ones.

Function
REQ-015 Each channel SHALL implement two states, IDLE and OPEN, plus a window-length counter of width clog2(MAX_WIN+1), minimum 1.
REQ-016 IDLE -> OPEN on a cycle with enable=1 and start_event=1; the counter loads 0; test_expr is not checked in the start cycle.
REQ-017 In OPEN with enable=1, test_expr SHALL be checked every cycle, including the end_event cycle; a false condition sets fire=1 and fire_code=01 in the next cycle.
REQ-018 OPEN -> IDLE on end_event=1, after that cycle's check.
REQ-019 start_event in OPEN SHALL be ignored and SHALL NOT restart the counter; end_event in IDLE SHALL be ignored.
REQ-020 start_event and end_event together in IDLE SHALL open the window.
REQ-021 With MAX_WIN>0, the counter increments each OPEN cycle without end_event; when it would reach MAX_WIN, the channel returns to IDLE and fires with code 10.
REQ-022 When a test_expr failure and a timeout occur in the same cycle, fire_code SHALL be 11 and one violation SHALL be counted.
REQ-023 A test_expr violation does not close the window; the channel fires once for each failing cycle.
REQ-024 fire_count SHALL add the number of channels firing in a cycle (popcount), saturating without wrap.
REQ-025 enable=0 SHALL force IDLE, clear the counters, and hold fire and fire_code at 0 from the next cycle; fire_count holds its value.
REQ-026 Latency: fire, fire_code and fire_count update exactly one clock after the sampled violation.

Reset
REQ-027 While reset=1, asynchronously: all channels IDLE, active=0, fire=0, fire_code=0, fire_count=0, window counters 0.
REQ-028 Reset asserted mid-window SHALL abort the window without firing; after release, a window opens only on a new start_event.

Structure
REQ-029 Package ovl_window_mc_pkg SHALL hold the state typedef (IDLE, OPEN) and the fire_code constants (FIRE_NONE, FIRE_EXPR, FIRE_TMO).
REQ-030 The per-channel FSM, counter and check SHALL be a sub-module ovl_window_ch, instantiated NUM_CH times by a generate loop; popcount and saturation live in the top level.

Verification
REQ-031 NUM_CH=4, WIDTH=1, MAX_WIN=16: ch0 start at cycle 10, test_expr=1, end at cycle 16 -> active=1 for cycles 11..16, no fire, fire_count=0.
REQ-032 ch1 start at cycle 10, test_expr=0 at cycle 13 only, end at cycle 15 -> fire[1]=1 at cycle 14 only, fire_code=01, fire_count=1.
REQ-033 ch2 start at cycle 10, no end_event -> fire[2] with code 10 at cycle 27, active[2]=0 from cycle 27, fire_count increments by 1.
REQ-034 ch0 and ch3 both fail test_expr in the same cycle -> fire=4'b1001, fire_count increments by 2; with CNT_W=2, repeated failures saturate at 3.
REQ-035 Window open on ch0, reset pulsed for 1 cycle, test_expr held 0 -> no fire, active=0, fire_count=0 after reset.
REQ-036 Window open with test_expr=0, enable dropped -> fire=0 from the next cycle, active=0; end_event in IDLE -> no effect.

Source files
------------

// File: rtl/ovl_window_mc_pkg.sv
// Shared types and constants for the multi-channel window checker.
package ovl_window_mc_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    OPEN = 1'b1
  } ch_state_t;

  localparam logic [1:0] FIRE_NONE = 2'b00;
  localparam logic [1:0] FIRE_EXPR = 2'b01;
  localparam logic [1:0] FIRE_TMO  = 2'b10;

  // Window counter width: clog2(max_win+1), never below one bit.
  function automatic int cnt_width(input int max_win);
    return (max_win < 1) ? 1 : $clog2(max_win + 1);
  endfunction

endpackage

// File: rtl/ovl_window_ch.sv
// One window channel: IDLE/OPEN FSM, window-length counter and condition check.
module ovl_window_ch
  import ovl_window_mc_pkg::*;
#(
  parameter int WIDTH   = 1,
  parameter int MAX_WIN = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             start_event,
  input  logic             end_event,
  input  logic [WIDTH-1:0] test_expr,
  output logic             active,
  output logic             fire,
  output logic [1:0]       fire_code,
  output logic             viol_p0
);

  localparam int CW = cnt_width(MAX_WIN);
  localparam logic [CW-1:0] CNT_LAST = CW'((MAX_WIN > 0) ? MAX_WIN - 1 : 0);

  ch_state_t     state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [1:0]    code_p0;
  logic          expr_fail, tmo;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      fire      <= 1'b0;
      fire_code <= FIRE_NONE;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      fire      <= viol_p0;
      fire_code <= code_p0;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    expr_fail = 1'b0;
    tmo       = 1'b0;
    if (!enable) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_event) begin
            state_nxt = OPEN;
            cnt_nxt   = '0;
          end
        end
        OPEN: begin
          expr_fail = !(&test_expr);
          // end_event wins over timeout; the window closes either way
          if (end_event) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
          end else if ((MAX_WIN > 0) && (cnt == CNT_LAST)) begin
            tmo       = 1'b1;
            state_nxt = IDLE;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
        default: begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  assign viol_p0 = expr_fail | tmo;
  assign code_p0 = (expr_fail ? FIRE_EXPR : FIRE_NONE) | (tmo ? FIRE_TMO : FIRE_NONE);
  assign active  = (state == OPEN);

endmodule

// File: rtl/ovl_window_mc.sv
// Multi-channel window checker: per-channel checkers plus a saturating violation count.
module ovl_window_mc
  import ovl_window_mc_pkg::*;
#(
  parameter int NUM_CH  = 4,
  parameter int WIDTH   = 1,
  parameter int MAX_WIN = 16,
  parameter int CNT_W   = 8
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [NUM_CH-1:0]       start_event,
  input  logic [NUM_CH-1:0]       end_event,
  input  logic [NUM_CH*WIDTH-1:0] test_expr,
  output logic [NUM_CH-1:0]       active,
  output logic [NUM_CH-1:0]       fire,
  output logic [NUM_CH*2-1:0]     fire_code,
  output logic [CNT_W-1:0]        fire_count
);

  logic [NUM_CH-1:0] viol_p0;

  function automatic logic [4:0] popcount(input logic [NUM_CH-1:0] v);
    logic [4:0] n;
    n = '0;
    for (int i = 0; i < NUM_CH; i++) n = n + {4'd0, v[i]};
    return n;
  endfunction

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] acc,
                                                input logic [4:0]       inc);
    logic [CNT_W+4:0] sum;
    sum = {5'd0, acc} + {{CNT_W{1'b0}}, inc};
    if (|sum[CNT_W+4:CNT_W]) return '1;
    return sum[CNT_W-1:0];
  endfunction

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    ovl_window_ch #(
      .WIDTH   (WIDTH),
      .MAX_WIN (MAX_WIN)
    ) u_ch (
      .clock       (clock),
      .reset       (reset),
      .enable      (enable),
      .start_event (start_event[c]),
      .end_event   (end_event[c]),
      .test_expr   (test_expr[c*WIDTH +: WIDTH]),
      .active      (active[c]),
      .fire        (fire[c]),
      .fire_code   (fire_code[2*c +: 2]),
      .viol_p0     (viol_p0[c])
    );
  end

  // p0 -> p1: count lands in the same cycle as the fire pulses it counts
  always_ff @(posedge clock or posedge reset) begin
    if (reset) fire_count <= '0;
    else       fire_count <= sat_add(fire_count, popcount(viol_p0));
  end

endmodule
